mem_burst: RTL
==============

MEM_BURST -- requirements
Module: mem_burst

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATAWIDTH, 32, data bits per word; multiple of 8.
- DEPTH, 256, words in the array; power of 2.
- BURSTLEN, 4, beats per burst; 1..16.
- RDLAT, 1, read pipeline latency in cycles; 1..4.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, input, 1, the single clock; all state changes on the rising edge.
- reset, input, 1, asynchronous active-high reset.
- req_valid, input, 1, burst request present.
- req_ready, output, 1, block can accept a request.
- req_write, input, 1, 1 = write burst, 0 = read burst.
- req_addr, input, $clog2(DEPTH), burst base address.
- wr_valid, input, 1, write beat present.
- wr_ready, output, 1, block accepts a write beat.
- wr_data, input, DATAWIDTH, write beat data.
- wr_be, input, DATAWIDTH/8, byte enables; bit k covers data[8k+7:8k].
- rd_valid, output, 1, read beat valid.
- rd_data, output, DATAWIDTH, read beat data.
- rd_last, output, 1, final beat of the read burst.

Function
REQ-003 The FSM SHALL have four states: IDLE, WRITE, READ, DRAIN.
REQ-004 req_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where req_valid && req_ready.
REQ-005 On acceptance, the block SHALL latch req_addr and req_write, clear the beat counter, and go to WRITE (req_write=1) or READ (req_write=0).
REQ-006 Beat i SHALL address (base + i) mod DEPTH, so bursts wrap past DEPTH-1 to 0.
REQ-007 WRITE SHALL hold wr_ready=1; each edge with wr_valid && wr_ready writes beat i.
- Only bytes whose wr_be bit is 1 are updated.
- The counter increments by one per written beat.
REQ-008 WRITE SHALL hold state indefinitely while wr_valid=0; after beat BURSTLEN-1 is written it returns to IDLE on that edge.
REQ-009 wr_ready SHALL be 0 outside WRITE; wr_valid outside WRITE is ignored with no array change.
REQ-010 READ SHALL issue one address per cycle for BURSTLEN consecutive cycles with no stalls, then go to DRAIN.
REQ-011 Read timing: if the request is accepted at edge E, beat i SHALL appear with rd_valid=1 in the cycle after edge E+1+i+RDLAT-1.
- For RDLAT=1, beat 0 is valid after edge E+1.
- Beats are contiguous and in order.
REQ-012 rd_last SHALL be 1 only with beat BURSTLEN-1; rd_valid=0 implies rd_last=0.
REQ-013 rd_data SHALL be 0 whenever rd_valid=0.
REQ-014 DRAIN SHALL go to IDLE on the edge where the final beat leaves the read pipeline, so req_ready rises in the cycle after rd_last.
REQ-015 There SHALL be no backpressure on read data; the consumer always accepts.
REQ-016 With BURSTLEN=1, READ SHALL last one cycle and WRITE SHALL complete on the first accepted beat.
REQ-017 An all-zero wr_be beat SHALL count as a beat but leave the array unchanged.

Reset
REQ-018 Asserting reset SHALL immediately (asynchronously) force:
- FSM to IDLE and beat counter to 0.
- The read pipeline flushed.
- Outputs: req_ready=1, wr_ready=0, rd_valid=0, rd_last=0, rd_data=0.
REQ-019 Reset asserted mid-burst SHALL abort the burst.
- Writes already committed remain.
- No further beats are written or returned.
REQ-020 Array contents SHALL NOT be altered by reset; they are zero at simulation start.
REQ-021 The first request SHALL be accepted on the first clock edge after reset deasserts.

Verification
REQ-022 Benches SHALL cover at least the following scenarios (DATAWIDTH=32, DEPTH=256, BURSTLEN=4, RDLAT=1 unless stated):
- Write burst at 0x10, data 0xA0..0xA3, wr_be=0xF, then read burst at 0x10 -> rd_data 0xA0,0xA1,0xA2,0xA3 on 4 consecutive cycles starting 2 cycles after acceptance; rd_last only on 0xA3.
- Write burst at 0xFE -> words land at 0xFE, 0xFF, 0x00, 0x01; read at 0xFE returns them in that order.
- Word 0x20 = 0x11223344, then write 0xAABBCCDD with wr_be=0b0101 -> read returns 0x11BB33DD.
- wr_valid held low 3 cycles mid-burst -> FSM stays in WRITE with wr_ready=1, no spurious writes; burst completes after 4 accepted beats.
- RDLAT=3 read burst -> beat 0 appears 4 cycles after acceptance; req_ready stays 0 until the cycle after rd_last.
- reset pulsed after beat 1 of a write burst -> rd_valid=0, req_ready=1 immediately; beats 0-1 are present and beats 2-3 unchanged.

Source files
------------

// File: rtl/mem_burst.sv
// Burst-oriented single-port word memory with byte-enable writes and a
// fixed-latency, non-stallable read pipeline.
module mem_burst #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned BURSTLEN  = 4,
  parameter int unsigned RDLAT     = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [$clog2(DEPTH)-1:0]   req_addr,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [DATAWIDTH-1:0]       wr_data,
  input  logic [DATAWIDTH/8-1:0]     wr_be,
  output logic                       rd_valid,
  output logic [DATAWIDTH-1:0]       rd_data,
  output logic                       rd_last
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NB = DATAWIDTH / 8;
  localparam int unsigned CW = $clog2(BURSTLEN + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURSTLEN - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [AW-1:0]   base, base_n;
  logic [AW-1:0]   beat_addr;
  logic            wr_en;
  logic            rd_issue;

  logic [DATAWIDTH-1:0] mem [DEPTH];

  logic [RDLAT-1:0]     pipe_valid;
  logic [RDLAT-1:0]     pipe_last;
  logic [DATAWIDTH-1:0] pipe_data [RDLAT];

  // Beat address wraps naturally modulo DEPTH through the AW-bit add.
  assign beat_addr = base + AW'(cnt);

  // Next-state, beat counter and datapath strobes.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    base_n   = base;
    wr_en    = 1'b0;
    rd_issue = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          base_n  = req_addr;
          cnt_n   = '0;
          state_n = req_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wr_valid) begin
          wr_en = 1'b1;
          if (cnt == LAST_BEAT) begin
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      READ: begin
        rd_issue = 1'b1;
        if (cnt == LAST_BEAT) begin
          cnt_n   = '0;
          state_n = DRAIN;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DRAIN: begin
        // Final beat is on the output this cycle; it leaves on this edge.
        if (rd_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and handshake outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      base      <= '0;
      req_ready <= 1'b1;
      wr_ready  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      base      <= base_n;
      req_ready <= (state_n == IDLE);
      wr_ready  <= (state_n == WRITE);
    end
  end

  // Array is never reset; only enabled bytes of an accepted beat change.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) mem[beat_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Read pipeline: stage 0 is the array read, later stages add latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid <= '0;
      pipe_last  <= '0;
      for (int k = 0; k < RDLAT; k++) pipe_data[k] <= '0;
    end else begin
      pipe_valid[0] <= rd_issue;
      pipe_last[0]  <= rd_issue && (cnt == LAST_BEAT);
      pipe_data[0]  <= rd_issue ? mem[beat_addr] : '0;
      for (int k = 1; k < RDLAT; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_last[k]  <= pipe_last[k-1];
        pipe_data[k]  <= pipe_data[k-1];
      end
    end
  end

  assign rd_valid = pipe_valid[RDLAT-1];
  assign rd_last  = pipe_last[RDLAT-1];
  assign rd_data  = pipe_data[RDLAT-1];

endmodule
